// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, default sizes and counter-width helper for the SPI master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV = 2;
  function automatic int cw(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period timer, ticks once every CLK_DIV cycles after a restart
module spi_clk_div import spi_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int W = cw(CLK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (reset || restart || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, one full-duplex frame per start; SPI_MASTER_LSB_FIRST_EN selects LSB-first
module spi_master import spi_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);
  localparam int BW = cw(DATA_WIDTH);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] tx_sr, tx_n, rx_sr, rs_n, rx_n, tx_shift, rx_shift;
  logic [BW-1:0] bit_cnt, bc_n;
  logic busy_n, done_n, sclk_n, cs_n, mosi_n, tick, restart;
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam int FIRST = 0;
  assign tx_shift = tx_sr >> 1;
  assign rx_shift = {MISO, rx_sr[DATA_WIDTH-1:1]};
`else
  localparam int FIRST = DATA_WIDTH - 1;
  assign tx_shift = tx_sr << 1;
  assign rx_shift = {rx_sr[DATA_WIDTH-2:0], MISO};
`endif
  assign restart = state == IDLE || state_n != state;
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .reset(reset), .restart(restart), .tick(tick));
  always_comb begin
    state_n = state;
    busy_n = busy;
    done_n = 1'b0;
    rx_n = rx_data;
    sclk_n = sclk;
    cs_n = CS;
    mosi_n = MOSI;
    tx_n = tx_sr;
    rs_n = rx_sr;
    bc_n = bit_cnt;
    case (state)
      IDLE: if (start) begin
        tx_n = tx_data;
        cs_n = 1'b0;
        mosi_n = tx_data[FIRST];
        busy_n = 1'b1;
        bc_n = '0;
        state_n = LEAD;
      end
      LEAD, LOW: if (tick) begin
        sclk_n = 1'b1;
        rs_n = rx_shift;
        state_n = HIGH;
      end
      HIGH: if (tick) begin
        sclk_n = 1'b0;
        if (bit_cnt == BW'(DATA_WIDTH - 1)) state_n = TRAIL;
        else begin
          bc_n = bit_cnt + 1'b1;
          tx_n = tx_shift;
          mosi_n = tx_shift[FIRST];
          state_n = LOW;
        end
      end
      TRAIL: if (tick) begin
        cs_n = 1'b1;
        rx_n = rx_sr;
        done_n = 1'b1;
        busy_n = 1'b0;
        mosi_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rx_data <= '0;
      sclk <= 1'b0;
      CS <= 1'b1;
      MOSI <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_n;
      busy <= busy_n;
      done <= done_n;
      rx_data <= rx_n;
      sclk <= sclk_n;
      CS <= cs_n;
      MOSI <= mosi_n;
      tx_sr <= tx_n;
      rx_sr <= rs_n;
      bit_cnt <= bc_n;
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed table and corner-case sequences for spi_master (default and CLK_DIV=1 instances)
module tb_spi_master;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sel = 1'b0, loop = 1'b1;
  logic [7:0] tx_data = '0;
  logic busy0, done0, sclk0, cs0, mosi0, miso0, busy1, done1, sclk1, cs1, mosi1;
  logic [7:0] rx0, rx1;
  logic s_miso;
  logic [7:0] sl_tx, sl_rx;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  assign miso0 = loop ? mosi0 : s_miso;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .start(start && !sel), .tx_data(tx_data), .busy(busy0), .done(done0),
    .rx_data(rx0), .sclk(sclk0), .CS(cs0), .MOSI(mosi0), .MISO(miso0));
  spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start && sel), .tx_data(tx_data), .busy(busy1), .done(done1),
    .rx_data(rx1), .sclk(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(mosi1));

  // mode-0 slave model: presents its MSB as CS falls, shifts out on sclk falling, captures on rising
  assign s_miso = sl_tx[7];
  always @(negedge cs0) sl_tx <= 8'hD4;
  always @(negedge sclk0) if (!cs0) sl_tx <= sl_tx << 1;
  always @(posedge sclk0) if (!cs0) sl_rx <= {sl_rx[6:0], mosi0};

  logic d_done, d_busy, d_cs, d_sclk, d_mosi;
  logic [7:0] d_rx;
  assign d_done = sel ? done1 : done0;
  assign d_busy = sel ? busy1 : busy0;
  assign d_cs = sel ? cs1 : cs0;
  assign d_sclk = sel ? sclk1 : sclk0;
  assign d_mosi = sel ? mosi1 : mosi0;
  assign d_rx = sel ? rx1 : rx0;

  typedef struct {
    logic       s;
    logic [7:0] tx;
    logic [7:0] rx;
    int         lat;
    int         mh;
  } vec_t;

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam int MH01 = 4;
  localparam logic [7:0] EXP_SL_RX = 8'h55;
  localparam logic [7:0] EXP_M_RX = 8'h2B;
`else
  localparam int MH01 = 6;
  localparam logic [7:0] EXP_SL_RX = 8'hAA;
  localparam logic [7:0] EXP_M_RX = 8'hD4;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic kick(input logic [7:0] tx);
    tx_data = tx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic watch(input int poke_at, input logic [7:0] poke_tx,
                       output int lat, output int bc, output int cc, output int rises, output int mh);
    int k = 0;
    logic prev = d_sclk;
    bc = 0; cc = 0; rises = 0; mh = 0;
    while (!d_done && k < 200) begin
      bc += int'(d_busy);
      cc += int'(!d_cs);
      mh += int'(d_mosi);
      if (k == poke_at) begin
        start = 1'b1;
        tx_data = poke_tx;
      end
      if (k == poke_at + 1) start = 1'b0;
      @(negedge clk);
      k++;
      if (d_sclk && !prev) rises++;
      prev = d_sclk;
    end
    lat = k;
    chk("busy_low_at_done", int'(d_busy), 0);
    chk("cs_high_at_done", int'(d_cs), 1);
  endtask

  initial begin
    vec_t vt[6];
    int lat, bc, cc, rises, mh, dn;
    vt[0] = '{1'b0, 8'hA5, 8'hA5, 34, -1};
    vt[1] = '{1'b0, 8'h00, 8'h00, 34, 0};
    vt[2] = '{1'b0, 8'hFF, 8'hFF, 34, 34};
    vt[3] = '{1'b0, 8'h01, 8'h01, 34, MH01};
    vt[4] = '{1'b1, 8'h5A, 8'h5A, 17, -1};
    vt[5] = '{1'b1, 8'hC3, 8'hC3, 17, -1};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_rx", int'(rx0), 0);
    chk("rst_sclk", int'(sclk0), 0);
    chk("rst_cs", int'(cs0), 1);
    chk("rst_mosi", int'(mosi0), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      sel = vt[i].s;
      kick(vt[i].tx);
      watch(-5, 8'h00, lat, bc, cc, rises, mh);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bc, vt[i].lat);
      chk($sformatf("v%0d_cs_low_cycles", i), cc, vt[i].lat);
      chk($sformatf("v%0d_sclk_rises", i), rises, 8);
      chk($sformatf("v%0d_rx", i), int'(d_rx), int'(vt[i].rx));
      if (vt[i].mh >= 0) chk($sformatf("v%0d_mosi_high_cycles", i), mh, vt[i].mh);
      repeat (3) @(negedge clk);
    end

    sel = 1'b0;
    kick(8'hA5);
    watch(10, 8'hFF, lat, bc, cc, rises, mh);
    chk("ignore_latency", lat, 34);
    chk("ignore_rx", int'(rx0), 8'hA5);
    kick(8'h3C);
    chk("b2b_cs_low_after_gap", int'(cs0), 0);
    chk("b2b_busy", int'(busy0), 1);
    watch(-5, 8'h00, lat, bc, cc, rises, mh);
    chk("b2b_latency", lat, 34);
    chk("b2b_rx", int'(rx0), 8'h3C);

    kick(8'hC3);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_cs", int'(cs0), 1);
    chk("abort_sclk", int'(sclk0), 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_rx", int'(rx0), 0);
    dn = 0;
    repeat (40) begin
      dn += int'(done0);
      @(negedge clk);
    end
    chk("abort_no_done", dn, 0);
    kick(8'h81);
    watch(-5, 8'h00, lat, bc, cc, rises, mh);
    chk("after_abort_latency", lat, 34);
    chk("after_abort_rx", int'(rx0), 8'h81);

    loop = 1'b0;
    repeat (2) @(negedge clk);
    kick(8'hAA);
    watch(-5, 8'h00, lat, bc, cc, rises, mh);
    chk("slave_master_rx", int'(rx0), int'(EXP_M_RX));
    chk("slave_rx", int'(sl_rx), int'(EXP_SL_RX));
    chk("slave_cs_low_cycles", cc, 34);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
